// File: rtl/alu_pkg.sv
// Shared constants and opcode encoding for the
// execute-stage ALU.
package alu_pkg;

    localparam int XLEN = 64;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_t;

endpackage

// File: rtl/adder64.sv
// Combinational W-bit adder with carry-in.
// Carry-out is discarded; the sum wraps.
module adder64 #(
    parameter int W = 64
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum
);

    assign sum = a + b + {{(W-1){1'b0}}, cin};

endmodule

// File: rtl/ex_alu_stage.sv
// Registered execute stage: ALU result, zero flag,
// branch target and sequential next PC.
module ex_alu_stage
    import alu_pkg::*;
#(
    parameter int XLEN    = alu_pkg::XLEN,
    parameter int PC_STEP = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [1:0]      alu_op,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    output logic            out_valid,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic [XLEN-1:0] branch_target,
    output logic [XLEN-1:0] pc_plus4
);

    localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

    alu_op_t         op;
    logic            is_sub;
    logic [XLEN-1:0] add_b;
    logic [XLEN-1:0] add_sum;
    logic [XLEN-1:0] imm_sh;
    logic [XLEN-1:0] bt_sum;
    logic [XLEN-1:0] pc4_sum;
    logic [XLEN-1:0] alu_res;

    assign op     = alu_op_t'(alu_op);
    assign is_sub = (op == ALU_SUB);
    assign add_b  = is_sub ? ~b : b;
    // Shift drops imm's MSB; branch offsets are halfword units.
    assign imm_sh = imm << 1;

    adder64 #(.W(XLEN)) u_alu_add (
        .a   (a),
        .b   (add_b),
        .cin (is_sub),
        .sum (add_sum)
    );

    adder64 #(.W(XLEN)) u_bt_add (
        .a   (pc),
        .b   (imm_sh),
        .cin (1'b0),
        .sum (bt_sum)
    );

    adder64 #(.W(XLEN)) u_pc4_add (
        .a   (pc),
        .b   (STEP),
        .cin (1'b0),
        .sum (pc4_sum)
    );

    always_comb begin
        alu_res = add_sum;
        unique case (op)
            ALU_ADD: alu_res = add_sum;
            ALU_SUB: alu_res = add_sum;
            ALU_AND: alu_res = a & b;
            ALU_OR:  alu_res = a | b;
            default: alu_res = add_sum;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid     <= 1'b0;
            result        <= '0;
            zero          <= 1'b0;
            branch_target <= '0;
            pc_plus4      <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                result        <= alu_res;
                zero          <= (alu_res == '0);
                branch_target <= bt_sum;
                pc_plus4      <= pc4_sum;
            end
        end
    end

endmodule

// File: tb/tb_ex_alu_stage.sv
// Directed self-checking bench for ex_alu_stage.
// Vectors carry hand-computed expected values.
module tb_ex_alu_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [63:0] a;
    logic [63:0] b;
    logic [1:0]  alu_op;
    logic [63:0] pc;
    logic [63:0] imm;
    logic        out_valid;
    logic [63:0] result;
    logic        zero;
    logic [63:0] branch_target;
    logic [63:0] pc_plus4;

    int errors = 0;
    int checks = 0;

    ex_alu_stage dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .a             (a),
        .b             (b),
        .alu_op        (alu_op),
        .pc            (pc),
        .imm           (imm),
        .out_valid     (out_valid),
        .result        (result),
        .zero          (zero),
        .branch_target (branch_target),
        .pc_plus4      (pc_plus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(
        input string       tag,
        input logic [63:0] got,
        input logic [63:0] exp
    );
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(
        input logic        v,
        input logic [63:0] ia,
        input logic [63:0] ib,
        input logic [1:0]  op,
        input logic [63:0] ipc,
        input logic [63:0] iimm
    );
        in_valid = v;
        a        = ia;
        b        = ib;
        alu_op   = op;
        pc       = ipc;
        imm      = iimm;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_all(
        input string       tag,
        input logic        ov,
        input logic [63:0] res,
        input logic        z,
        input logic [63:0] bt,
        input logic [63:0] p4
    );
        check({tag, ".valid"}, {63'd0, out_valid}, {63'd0, ov});
        check({tag, ".result"}, result, res);
        check({tag, ".zero"}, {63'd0, zero}, {63'd0, z});
        check({tag, ".bt"}, branch_target, bt);
        check({tag, ".pc4"}, pc_plus4, p4);
    endtask

    initial begin
        rst      = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        alu_op   = 2'b00;
        pc       = '0;
        imm      = '0;
        #1;
        check_all("reset", 1'b0, 64'd0, 1'b0, 64'd0, 64'd0);

        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_all("post_rel", 1'b0, 64'd0, 1'b0, 64'd0, 64'd0);

        drive(1'b1, 64'd5, 64'd7, 2'b00, 64'h100, 64'h10);
        check_all("add", 1'b1, 64'd12, 1'b0, 64'h120, 64'h104);

        drive(1'b1, 64'h1234, 64'h1234, 2'b01, 64'h200, 64'h0);
        check_all("sub_eq", 1'b1, 64'd0, 1'b1, 64'h200, 64'h204);

        drive(1'b1, 64'd0, 64'd1, 2'b01, 64'h300, 64'h8);
        check_all("sub_wrap", 1'b1, 64'hFFFF_FFFF_FFFF_FFFF,
                  1'b0, 64'h310, 64'h304);

        drive(1'b1, 64'hF0F0, 64'h0FF0, 2'b10, 64'h400, 64'h1);
        check_all("and", 1'b1, 64'h00F0, 1'b0, 64'h402, 64'h404);

        drive(1'b1, 64'hF0F0, 64'h0FF0, 2'b11, 64'h500, 64'h2);
        check_all("or", 1'b1, 64'hFFF0, 1'b0, 64'h504, 64'h504);

        drive(1'b1, 64'hF0F0, 64'h0F0F, 2'b10, 64'h600, 64'h0);
        check_all("and_zero", 1'b1, 64'd0, 1'b1, 64'h600, 64'h604);

        drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 2'b00,
              64'h700, 64'h0);
        check_all("add_wrap", 1'b1, 64'd0, 1'b1, 64'h700, 64'h704);

        drive(1'b1, 64'd10, 64'd3, 2'b01, 64'h800, 64'h0);
        check_all("sub_pos", 1'b1, 64'd7, 1'b0, 64'h800, 64'h804);

        drive(1'b0, 64'hDEAD, 64'hBEEF, 2'b11, 64'h900, 64'h40);
        check_all("hold1", 1'b0, 64'd7, 1'b0, 64'h800, 64'h804);
        drive(1'b0, 64'h0, 64'h0, 2'b01, 64'hA00, 64'h0);
        check_all("hold2", 1'b0, 64'd7, 1'b0, 64'h800, 64'h804);

        drive(1'b1, 64'd1, 64'd1, 2'b00,
              64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC);
        check_all("pc_wrap", 1'b1, 64'd2, 1'b0,
                  64'hFFFF_FFFF_FFFF_FFF4, 64'd0);

        drive(1'b1, 64'd0, 64'd0, 2'b11, 64'h100,
              64'hFFFF_FFFF_FFFF_FFFC);
        check_all("neg_imm", 1'b1, 64'd0, 1'b1, 64'hF8, 64'h104);

        drive(1'b1, 64'd1, 64'd2, 2'b11, 64'h0,
              64'h8000_0000_0000_0001);
        check_all("imm_msb", 1'b1, 64'd3, 1'b0, 64'h2, 64'h4);

        in_valid = 1'b1;
        a        = 64'd9;
        b        = 64'd9;
        alu_op   = 2'b00;
        #1;
        rst = 1'b0;
        #1;
        check_all("mid_rst", 1'b0, 64'd0, 1'b0, 64'd0, 64'd0);
        @(negedge clk);
        check_all("rst_held", 1'b0, 64'd0, 1'b0, 64'd0, 64'd0);
        rst = 1'b1;
        drive(1'b0, 64'd1, 64'd1, 2'b00, 64'h10, 64'h0);
        check_all("rel_idle", 1'b0, 64'd0, 1'b0, 64'd0, 64'd0);
        drive(1'b1, 64'd4, 64'd6, 2'b00, 64'h20, 64'h3);
        check_all("rel_add", 1'b1, 64'd10, 1'b0, 64'h26, 64'h24);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
